// File: rtl/sample_framer.sv
// Packs SPI sample bytes into ping-pong frames of signed fixed-point words for the FFT core.
// Optional macro FRAMER_DROP_CNT_EN adds a saturating 16-bit dropped-sample counter output.
module sample_framer #(
   parameter int SPI_WIDTH  = 8,
   parameter int DATA_WIDTH = 16,
   parameter int FRAME_LEN  = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int GUARD_BITS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  received_wd,
   input  logic [SPI_WIDTH-1:0]  sample_in,
   input  logic                  fft_done,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  fft_start,
   output logic                  frame_flag,
   output logic                  rd_bank,
   output logic                  overrun
`ifdef FRAMER_DROP_CNT_EN
   ,
   output logic [15:0]           drop_cnt
`endif
);

   localparam int SHIFT = DATA_WIDTH - SPI_WIDTH - GUARD_BITS;
   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(FRAME_LEN - 1);

   typedef enum logic [1:0] {RD_IDLE, RD_START, RD_BUSY} rd_state_t;
   typedef enum logic {WR_FILL, WR_HOLD} wr_state_t;

   rd_state_t rd_state_reg, rd_state_next;
   wr_state_t wr_state_reg, wr_state_next;
   logic                  wr_bank_reg, wr_bank_next;
   logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
   logic                  rd_bank_reg, rd_bank_next;
   logic                  overrun_reg, overrun_next;
`ifdef FRAMER_DROP_CNT_EN
   logic [15:0]           drop_cnt_reg, drop_cnt_next;
`endif

   logic                  done_busy;
   logic                  rd_free;
   logic                  handoff;
   logic                  mem_we;
   logic [ADDR_WIDTH:0]   wr_addr;

   // Offset binary -> two's complement by flipping the MSB, then scale into the headroom.
   logic [SPI_WIDTH-1:0]  flipped;
   logic [DATA_WIDTH-1:0] extended;
   logic [DATA_WIDTH-1:0] converted;

   assign flipped   = {~sample_in[SPI_WIDTH-1], sample_in[SPI_WIDTH-2:0]};
   assign extended  = {{(DATA_WIDTH-SPI_WIDTH){flipped[SPI_WIDTH-1]}}, flipped};
   assign converted = extended << SHIFT;

   logic [DATA_WIDTH-1:0] mem [0:2*FRAME_LEN-1];

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[wr_addr] <= converted;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rd_data <= '0;
      else
         rd_data <= mem[{rd_bank_reg, rd_addr}];
   end

   // A completing frame may hand off in the same cycle the FFT releases its bank.
   assign done_busy = (rd_state_reg == RD_BUSY) && fft_done;
   assign rd_free   = (rd_state_reg == RD_IDLE) || done_busy;

   always_comb begin
      wr_state_next = wr_state_reg;
      wr_bank_next  = wr_bank_reg;
      wr_ptr_next   = wr_ptr_reg;
      rd_bank_next  = rd_bank_reg;
      overrun_next  = overrun_reg;
`ifdef FRAMER_DROP_CNT_EN
      drop_cnt_next = drop_cnt_reg;
`endif
      handoff       = 1'b0;
      mem_we        = 1'b0;
      wr_addr       = {wr_bank_reg, wr_ptr_reg};

      case (wr_state_reg)
         WR_FILL: begin
            if (received_wd) begin
               mem_we = 1'b1;
               if (wr_ptr_reg != LAST_PTR) begin
                  wr_ptr_next = wr_ptr_reg + ADDR_WIDTH'(1);
               end else begin
                  wr_ptr_next = '0;
                  if (rd_free)
                     handoff = 1'b1;
                  else
                     wr_state_next = WR_HOLD;
               end
            end
         end
         WR_HOLD: begin
            if (done_busy) begin
               handoff       = 1'b1;
               wr_state_next = WR_FILL;
               // The sample arriving with the release lands at index 0 of the freed bank.
               if (received_wd) begin
                  mem_we      = 1'b1;
                  wr_addr     = {~wr_bank_reg, {ADDR_WIDTH{1'b0}}};
                  wr_ptr_next = ADDR_WIDTH'(1);
               end
            end else if (received_wd) begin
               overrun_next = 1'b1;
`ifdef FRAMER_DROP_CNT_EN
               if (drop_cnt_reg != 16'hFFFF)
                  drop_cnt_next = drop_cnt_reg + 16'd1;
`endif
            end
         end
         default: wr_state_next = WR_FILL;
      endcase

      if (handoff) begin
         rd_bank_next = wr_bank_reg;
         wr_bank_next = ~wr_bank_reg;
      end
   end

   always_comb begin
      rd_state_next = rd_state_reg;
      case (rd_state_reg)
         RD_IDLE:  if (handoff) rd_state_next = RD_START;
         RD_START: rd_state_next = RD_BUSY;
         RD_BUSY:  if (fft_done) rd_state_next = handoff ? RD_START : RD_IDLE;
         default:  rd_state_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state_reg <= RD_IDLE;
         wr_state_reg <= WR_FILL;
         wr_bank_reg  <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_bank_reg  <= 1'b1;
         overrun_reg  <= 1'b0;
`ifdef FRAMER_DROP_CNT_EN
         drop_cnt_reg <= 16'd0;
`endif
      end else begin
         rd_state_reg <= rd_state_next;
         wr_state_reg <= wr_state_next;
         wr_bank_reg  <= wr_bank_next;
         wr_ptr_reg   <= wr_ptr_next;
         rd_bank_reg  <= rd_bank_next;
         overrun_reg  <= overrun_next;
`ifdef FRAMER_DROP_CNT_EN
         drop_cnt_reg <= drop_cnt_next;
`endif
      end
   end

   assign fft_start  = (rd_state_reg == RD_START);
   assign frame_flag = (rd_state_reg != RD_IDLE);
   assign rd_bank    = rd_bank_reg;
   assign overrun    = overrun_reg;
`ifdef FRAMER_DROP_CNT_EN
   assign drop_cnt   = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_sample_framer.sv
// Directed self-checking bench for sample_framer (define FRAMER_DROP_CNT_EN to cover drop_cnt).
module tb_sample_framer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        received_wd = 1'b0;
   logic [7:0]  sample_in = 8'h00;
   logic        fft_done = 1'b0;
   logic [4:0]  rd_addr = 5'd0;
   logic [15:0] rd_data;
   logic        fft_start;
   logic        frame_flag;
   logic        rd_bank;
   logic        overrun;
`ifdef FRAMER_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int tests = 0;
   int fails = 0;
   int start_cnt = 0;

   sample_framer dut (
      .clk         (clk),
      .reset       (reset),
      .received_wd (received_wd),
      .sample_in   (sample_in),
      .fft_done    (fft_done),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .fft_start   (fft_start),
      .frame_flag  (frame_flag),
      .rd_bank     (rd_bank),
      .overrun     (overrun)
`ifdef FRAMER_DROP_CNT_EN
      ,
      .drop_cnt    (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fft_start) start_cnt = start_cnt + 1;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] v);
      @(negedge clk);
      received_wd = 1'b1;
      sample_in   = v;
      @(negedge clk);
      received_wd = 1'b0;
   endtask

   task automatic done_pulse();
      @(negedge clk);
      fft_done = 1'b1;
      @(negedge clk);
      fft_done = 1'b0;
   endtask

   task automatic read_check(input string tag, input logic [4:0] a, input logic [15:0] e);
      @(negedge clk);
      rd_addr = a;
      @(negedge clk);
      check(tag, {16'h0, rd_data}, {16'h0, e});
      $display("[TB] read addr=%0d data=%04h", a, rd_data);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start_cnt = 0;
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_fft_start", {31'h0, fft_start}, 32'h0);
      check("rst_frame_flag", {31'h0, frame_flag}, 32'h0);
      check("rst_overrun", {31'h0, overrun}, 32'h0);
      check("rst_rd_data", {16'h0, rd_data}, 32'h0);
      check("rst_rd_bank", {31'h0, rd_bank}, 32'h1);
`ifdef FRAMER_DROP_CNT_EN
      check("rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
`endif

      // First frame: samples 0..31
      for (int i = 0; i < 31; i++) send(8'(i));
      check("f1_no_early_start", {31'h0, fft_start}, 32'h0);
      send(8'd31);
      check("f1_start_pulse", {31'h0, fft_start}, 32'h1);
      check("f1_frame_flag", {31'h0, frame_flag}, 32'h1);
      check("f1_rd_bank", {31'h0, rd_bank}, 32'h0);
      @(negedge clk);
      check("f1_start_one_cycle", {31'h0, fft_start}, 32'h0);
      check("f1_start_count", start_cnt, 32'd1);
      $display("[TB] frame1 handed off rd_bank=%0d starts=%0d", rd_bank, start_cnt);
      read_check("f1_rd0", 5'd0, 16'hFC00);
      read_check("f1_rd1", 5'd1, 16'hFC08);
      read_check("f1_rd31", 5'd31, 16'hFCF8);
      done_pulse();
      check("f1_flag_cleared", {31'h0, frame_flag}, 32'h0);

      // Conversion sweep into bank 1
      send(8'hFF);
      send(8'h80);
      send(8'h7F);
      send(8'h00);
      for (int i = 0; i < 28; i++) send(8'h55);
      check("cv_start_pulse", {31'h0, fft_start}, 32'h1);
      check("cv_rd_bank", {31'h0, rd_bank}, 32'h1);
      read_check("cv_ff", 5'd0, 16'h03F8);
      read_check("cv_80", 5'd1, 16'h0000);
      read_check("cv_7f", 5'd2, 16'hFFF8);
      read_check("cv_00", 5'd3, 16'hFC00);
      done_pulse();

      // Overrun: two frames with fft_done withheld, then 3 drops
      do_reset();
      for (int i = 0; i < 64; i++) send(8'(i));
      check("ov_none_yet", {31'h0, overrun}, 32'h0);
      check("ov_one_start", start_cnt, 32'd1);
      for (int i = 0; i < 3; i++) send(8'hFF);
      check("ov_sticky", {31'h0, overrun}, 32'h1);
      check("ov_flag_held", {31'h0, frame_flag}, 32'h1);
      check("ov_bank_held", {31'h0, rd_bank}, 32'h0);
      done_pulse();
      check("ov_start_after_done", {31'h0, fft_start}, 32'h1);
      check("ov_rd_bank", {31'h0, rd_bank}, 32'h1);
      check("ov_flag_stays", {31'h0, frame_flag}, 32'h1);
      $display("[TB] hold released rd_bank=%0d overrun=%0d", rd_bank, overrun);
      read_check("ov_rd0_kept", 5'd0, 16'hFD00);
      read_check("ov_rd31_kept", 5'd31, 16'hFDF8);
      read_check("ov_rd0_again", 5'd0, 16'hFD00);

      // Async reset mid-frame (idx 17) while BUSY
      for (int i = 0; i < 17; i++) send(8'hAA);
      #2;
      reset = 1'b1;
      #1;
      check("ar_fft_start", {31'h0, fft_start}, 32'h0);
      check("ar_frame_flag", {31'h0, frame_flag}, 32'h0);
      check("ar_overrun", {31'h0, overrun}, 32'h0);
      check("ar_rd_data", {16'h0, rd_data}, 32'h0);
      check("ar_rd_bank", {31'h0, rd_bank}, 32'h1);
      $display("[TB] async reset applied mid-frame");
      @(negedge clk);
      reset = 1'b0;
      start_cnt = 0;
      for (int i = 0; i < 32; i++) send(8'hC0);
      check("ar_fresh_start", {31'h0, fft_start}, 32'h1);
      check("ar_fresh_bank", {31'h0, rd_bank}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("ar_fresh_count", start_cnt, 32'd1);
      read_check("ar_fresh_rd0", 5'd0, 16'h0200);

      // fft_done and received_wd together in HOLD
      do_reset();
      for (int i = 0; i < 64; i++) send(8'h10);
      @(negedge clk);
      fft_done    = 1'b1;
      received_wd = 1'b1;
      sample_in   = 8'h11;
      @(negedge clk);
      fft_done    = 1'b0;
      received_wd = 1'b0;
      check("sc_start", {31'h0, fft_start}, 32'h1);
      check("sc_rd_bank", {31'h0, rd_bank}, 32'h1);
      check("sc_no_overrun", {31'h0, overrun}, 32'h0);
      for (int i = 0; i < 31; i++) send(8'(8'h40 + i));
      check("sc_hold_no_start", {31'h0, fft_start}, 32'h0);
      done_pulse();
      check("sc_start2", {31'h0, fft_start}, 32'h1);
      check("sc_rd_bank2", {31'h0, rd_bank}, 32'h0);
      read_check("sc_idx0", 5'd0, 16'hFC88);
      read_check("sc_idx1", 5'd1, 16'hFE00);
      check("sc_overrun_end", {31'h0, overrun}, 32'h0);

`ifdef FRAMER_DROP_CNT_EN
      do_reset();
      check("dc_reset", {16'h0, drop_cnt}, 32'h0);
      for (int i = 0; i < 64; i++) send(8'h00);
      for (int i = 0; i < 5; i++) send(8'h00);
      check("dc_five", {16'h0, drop_cnt}, 32'd5);
      @(negedge clk);
      received_wd = 1'b1;
      repeat (70000) @(negedge clk);
      received_wd = 1'b0;
      check("dc_saturate", {16'h0, drop_cnt}, 32'h0000FFFF);
      $display("[TB] drop_cnt after forced drops=%04h", drop_cnt);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
